// File: rtl/sevenseg_display.sv
// Four-digit common-anode MM.SS display driver with anode scanning,
// per-frame snapshot of the time value and field blinking in adjust mode.
module sevenseg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adjust,
    input  logic       select,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [5:0]    r_snap_min;
    logic [5:0]    r_snap_sec;
    logic          r_adj;
    logic          r_sel;
    logic          r_blk;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic [5:0]    w_field;
    logic [7:0]    w_bcd;
    logic [3:0]    w_digit;
    logic [6:0]    w_glyph;
    logic          w_blank;

    // Repeated subtraction is enough for a 0..59 value and avoids a divider.
    function automatic logic [7:0] split_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] t;
        rem = v;
        t   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem = rem - 6'd10;
                t   = t + 4'd1;
            end
        end
        return {t, rem[3:0]};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    assign w_tick = (r_cnt == CNT_LAST);

    always_comb begin
        w_field = r_idx[1] ? r_snap_min : r_snap_sec;
        w_bcd   = split_bcd(w_field);
        w_digit = r_idx[0] ? w_bcd[7:4] : w_bcd[3:0];
        w_glyph = (w_field >= 6'd60) ? SEG_DASH : glyph(w_digit);
        // select=1 owns slots 0,1 (seconds); select=0 owns slots 2,3 (minutes)
        w_blank = r_adj & r_blk & (r_sel == ~r_idx[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_snap_min <= 6'd0;
            r_snap_sec <= 6'd0;
            r_adj      <= 1'b0;
            r_sel      <= 1'b0;
            r_blk      <= 1'b0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_OFF;
            r_dp       <= 1'b1;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
                // Latch at frame wrap so every digit of a frame shows one value.
                if (r_idx == 2'd3) begin
                    r_snap_min <= minutes;
                    r_snap_sec <= seconds;
                end
            end
            r_adj <= adjust;
            r_sel <= select;
            r_blk <= blink;
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? SEG_OFF : w_glyph;
            r_dp  <= (r_idx != 2'd2);
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_display.sv
// Bench for sevenseg_display: directed scenarios followed by random inputs,
// every cycle compared with a time-based reference model of the display.
module tb_sevenseg_display;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       reset;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adjust;
    logic       select;
    logic       blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;

    sevenseg_display #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .minutes (minutes),
        .seconds (seconds),
        .adjust  (adjust),
        .select  (select),
        .blink   (blink),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: display content derived from elapsed clocks since release.
    logic [6:0] glyph_tab [10];
    int         k;
    int         snap_m, snap_s;
    logic       p_adj, p_sel, p_blk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_rst;
    logic       m_valid = 1'b0;

    initial begin
        glyph_tab[0] = 7'b1000000; glyph_tab[1] = 7'b1111001;
        glyph_tab[2] = 7'b0100100; glyph_tab[3] = 7'b0110000;
        glyph_tab[4] = 7'b0011001; glyph_tab[5] = 7'b0010010;
        glyph_tab[6] = 7'b0000010; glyph_tab[7] = 7'b1111000;
        glyph_tab[8] = 7'b0000000; glyph_tab[9] = 7'b0010000;
    end

    always @(posedge clk) begin
        int slot, v, d;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_rst = 1'b1;
            k = 0; snap_m = 0; snap_s = 0;
            p_adj = 1'b0; p_sel = 1'b0; p_blk = 1'b0;
        end else begin
            slot = (k / DIV) % 4;
            v    = (slot >= 2) ? snap_m : snap_s;
            d    = (slot % 2 == 1) ? v / 10 : v % 10;
            e_seg = (v >= 60) ? 7'b0111111 : glyph_tab[d];
            if (p_adj && p_blk && ((p_sel == 1'b1) == (slot < 2)))
                e_seg = 7'h7F;
            e_an  = ~(4'b0001 << slot);
            e_dp  = (slot != 2);
            e_rst = 1'b0;
            if (k % FRAME == FRAME - 1) begin
                snap_m = minutes;
                snap_s = seconds;
            end
            k++;
            p_adj = adjust; p_sel = select; p_blk = blink;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("an",  32'(an),  32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dp",  32'(dp),  32'(e_dp));
            if (!e_rst)
                chk("an_onehot", 32'($countones(~an)), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input int m, input int s, input logic a, input logic sl, input logic b);
        minutes = 6'(m); seconds = 6'(s); adjust = a; select = sl; blink = b;
    endtask

    initial begin
        reset = 1'b1;
        set_in(12, 34, 1'b0, 1'b0, 1'b0);
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("first_slot_an",  32'(an),  32'(4'b1110));
        chk("first_slot_seg", 32'(seg), 32'(7'b1000000));
        cyc(FRAME * 3 - 1);
        // Mid-frame change: current frame must keep the old value.
        cyc(2 * DIV + 1);
        seconds = 6'd35;
        cyc(FRAME * 2);
        set_in(59, 59, 1'b1, 1'b1, 1'b1);
        cyc(FRAME * 2);
        blink = 1'b0;
        cyc(FRAME);
        select = 1'b0; blink = 1'b1;
        cyc(FRAME);
        adjust = 1'b0;
        cyc(FRAME);
        set_in(63, 0, 1'b0, 1'b0, 1'b0);
        cyc(FRAME * 2);
        set_in(12, 34, 1'b0, 1'b0, 1'b0);
        cyc(FRAME + 2 * DIV + 1);
        reset = 1'b1;
        cyc(1);
        chk("midscan_reset_an", 32'(an), 32'(4'hF));
        reset = 1'b0;
        cyc(FRAME * 3);
        for (int i = 0; i < 250; i++) begin
            set_in(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end
            cyc(int'($urandom_range(1, 2 * FRAME)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
